// File: rtl/video_mnist_argmax.sv
// Per-pixel argmax decoder: a stallable shift pipeline that reduces NUM_CLASS
// unsigned scores to the winning class index, its score and a detect flag,
// carrying tuser/tlast alongside each beat.
module video_mnist_argmax #(
  parameter int TUSER_WIDTH   = 1,
  parameter int NUM_CLASS     = 10,
  parameter int COUNT_WIDTH   = 7,
  parameter int S_TDATA_WIDTH = NUM_CLASS * COUNT_WIDTH,
  parameter int CLASS_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COUNT_WIDTH-1:0]   param_threshold,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [CLASS_WIDTH-1:0]   m_axi4s_tclass,
  output logic [COUNT_WIDTH-1:0]   m_axi4s_tcount,
  output logic                     m_axi4s_tdetect,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready
);

  // Number of compare-tree levels; stage 0 plus LEVELS gives the full depth.
  localparam int LEVELS = $clog2(NUM_CLASS);

  // Stage 0 holds the raw scores; stage l (1..LEVELS) holds the survivors of
  // tree level l in its low entries. Unused high entries are held at zero.
  logic [COUNT_WIDTH-1:0] cnt_reg   [0:LEVELS][NUM_CLASS];
  logic [CLASS_WIDTH-1:0] cls_reg   [1:LEVELS][NUM_CLASS];
  logic [COUNT_WIDTH-1:0] thr_reg   [0:LEVELS-1];
  logic [TUSER_WIDTH-1:0] user_reg  [0:LEVELS];
  logic                   last_reg  [0:LEVELS];
  logic                   valid_reg [0:LEVELS];
  logic                   det_reg;

  // Combinational winners feeding each tree level register.
  logic [COUNT_WIDTH-1:0] win_cnt [1:LEVELS][NUM_CLASS];
  logic [CLASS_WIDTH-1:0] win_cls [1:LEVELS][NUM_CLASS];

  logic cke;

  // The whole pipe advances whenever the output slot is empty or being taken.
  assign cke            = ~valid_reg[LEVELS] | m_axi4s_tready;
  assign s_axi4s_tready = cke;

  genvar gi, gj;
  generate
    for (gi = 1; gi <= LEVELS; gi++) begin : g_lvl
      localparam int N_IN  = (NUM_CLASS + (1 << (gi - 1)) - 1) >> (gi - 1);
      localparam int N_OUT = (N_IN + 1) / 2;
      for (gj = 0; gj < NUM_CLASS; gj++) begin : g_node
        if ((gj < N_OUT) && (2 * gj + 1 < N_IN)) begin : g_pair
          logic [COUNT_WIDTH-1:0] a_cnt, b_cnt;
          logic [CLASS_WIDTH-1:0] a_cls, b_cls;
          assign a_cnt = cnt_reg[gi-1][2*gj];
          assign b_cnt = cnt_reg[gi-1][2*gj+1];
          if (gi == 1) begin : g_idx
            assign a_cls = CLASS_WIDTH'(2 * gj);
            assign b_cls = CLASS_WIDTH'(2 * gj + 1);
          end else begin : g_fwd
            assign a_cls = cls_reg[gi-1][2*gj];
            assign b_cls = cls_reg[gi-1][2*gj+1];
          end
          // Strict compare: the lower index keeps ties.
          assign win_cnt[gi][gj] = (b_cnt > a_cnt) ? b_cnt : a_cnt;
          assign win_cls[gi][gj] = (b_cnt > a_cnt) ? b_cls : a_cls;
        end else if (gj < N_OUT) begin : g_pass
          assign win_cnt[gi][gj] = cnt_reg[gi-1][2*gj];
          if (gi == 1) begin : g_idx
            assign win_cls[gi][gj] = CLASS_WIDTH'(2 * gj);
          end else begin : g_fwd
            assign win_cls[gi][gj] = cls_reg[gi-1][2*gj];
          end
        end else begin : g_unused
          assign win_cnt[gi][gj] = '0;
          assign win_cls[gi][gj] = '0;
        end
      end
    end
  endgenerate

  // Shift every stage forward on cke; reset drops all in-flight beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l <= LEVELS; l++) begin
        valid_reg[l] <= 1'b0;
        user_reg[l]  <= '0;
        last_reg[l]  <= 1'b0;
        for (int k = 0; k < NUM_CLASS; k++) cnt_reg[l][k] <= '0;
      end
      for (int l = 1; l <= LEVELS; l++) begin
        for (int k = 0; k < NUM_CLASS; k++) cls_reg[l][k] <= '0;
      end
      for (int l = 0; l < LEVELS; l++) thr_reg[l] <= '0;
      det_reg <= 1'b0;
    end else if (cke) begin
      valid_reg[0] <= s_axi4s_tvalid;
      user_reg[0]  <= s_axi4s_tuser;
      last_reg[0]  <= s_axi4s_tlast;
      thr_reg[0]   <= param_threshold;
      for (int k = 0; k < NUM_CLASS; k++) begin
        cnt_reg[0][k] <= s_axi4s_tdata[k*COUNT_WIDTH +: COUNT_WIDTH];
      end
      for (int l = 1; l <= LEVELS; l++) begin
        valid_reg[l] <= valid_reg[l-1];
        user_reg[l]  <= user_reg[l-1];
        last_reg[l]  <= last_reg[l-1];
        for (int k = 0; k < NUM_CLASS; k++) begin
          cnt_reg[l][k] <= win_cnt[l][k];
          cls_reg[l][k] <= win_cls[l][k];
        end
      end
      for (int l = 1; l < LEVELS; l++) thr_reg[l] <= thr_reg[l-1];
      // Threshold travels with its beat, so detect uses the per-beat value.
      det_reg <= (win_cnt[LEVELS][0] >= thr_reg[LEVELS-1]);
    end
  end

  assign m_axi4s_tvalid  = valid_reg[LEVELS];
  assign m_axi4s_tuser   = user_reg[LEVELS];
  assign m_axi4s_tlast   = last_reg[LEVELS];
  assign m_axi4s_tclass  = cls_reg[LEVELS][0];
  assign m_axi4s_tcount  = cnt_reg[LEVELS][0];
  assign m_axi4s_tdetect = det_reg;

endmodule

// File: doc/video_mnist_argmax.md
# video_mnist_argmax

Pipelined per-pixel argmax decoder for the MNIST CNN video path. It consumes the AXI4-Stream produced by the CNN core, where each beat carries NUM_CLASS unsigned class scores. For each beat it emits the winning class index, its score and a detect flag. Sideband (tuser/tlast) is carried through in lock-step, so the overlay and label-drawing logic downstream receives one decision per pixel.

## Interface
- TUSER_WIDTH, 1, width of the tuser sideband carried through.
- NUM_CLASS, 10, number of class scores per beat (2..16).
- COUNT_WIDTH, 7, width of each unsigned class score.
- S_TDATA_WIDTH, NUM_CLASS*COUNT_WIDTH, input data width (70).
- CLASS_WIDTH, 4, width of the class index; must hold NUM_CLASS.

- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- param_threshold  in  COUNT_WIDTH  minimum winning score for detect=1.
- s_axi4s_tuser  in  TUSER_WIDTH  sideband (frame start).
- s_axi4s_tlast  in  1  end of line.
- s_axi4s_tdata  in  S_TDATA_WIDTH  class k score at [k*COUNT_WIDTH +: COUNT_WIDTH].
- s_axi4s_tvalid  in  1  input beat valid.
- s_axi4s_tready  out  1  input accepted when high with tvalid.
- m_axi4s_tuser  out  TUSER_WIDTH  delayed tuser.
- m_axi4s_tlast  out  1  delayed tlast.
- m_axi4s_tclass  out  CLASS_WIDTH  index of the maximum score.
- m_axi4s_tcount  out  COUNT_WIDTH  maximum score value.
- m_axi4s_tdetect  out  1  1 when tcount >= threshold captured with the beat.
- m_axi4s_tvalid  out  1  output beat valid.
- m_axi4s_tready  in  1  downstream ready.

## Operation
- Pipeline depth D = 1 + ceil(log2(NUM_CLASS)). D = 5 for 10 classes.
  - Stage 0 registers the input scores, tuser, tlast and param_threshold. The threshold is captured per beat, so a change mid-frame takes effect from the next accepted beat.
  - Stages 1..D-1 form a compare tree. Each level pairs adjacent candidates (a = lower index, b = higher index) and keeps b only if b.count > a.count (strict). An odd last candidate passes through unchanged.
- Tie rule: the lowest class index among equal maxima wins.
- The last stage computes detect = (count >= threshold), an unsigned compare. It also carries tuser and tlast forward.
- Each stage holds a valid bit. There is no internal FSM; the block is a stallable shift pipeline.
- The pipeline enable is cke = ~m_axi4s_tvalid | m_axi4s_tready.
  - s_axi4s_tready = cke. This is a combinational path from m_axi4s_tready; it is intentional.
  - When cke=1, every stage loads from the previous stage, and stage 0 loads from the input with valid = s_axi4s_tvalid.
  - When cke=0, all stages hold.
- Bubbles are not compressed: pipeline occupancy while stalled stays at most D beats.
- Beat order is preserved. tuser and tlast are never altered.

## Timing
- Reset (synchronous) clears all valid bits and sets every output to 0: m_axi4s_tvalid, tuser, tlast, tclass, tcount and tdetect. s_axi4s_tready is 1 in the cycle after reset.
- Reset asserted mid-stream discards all in-flight beats. No partial beat appears after reset deasserts.
- Latency: a beat accepted at edge N appears on m_axi4s with tvalid=1 after edge N+D, with no stall.
- Throughput: one beat per clock while m_axi4s_tready=1.
- Stall: while m_axi4s_tvalid=1 and m_axi4s_tready=0, all m_axi4s_* outputs stay stable and s_axi4s_tready=0.
- Full pipeline: with m_axi4s_tready=0, the pipeline stops accepting only once the output stage is valid. It then holds at most D beats and loses none.
- Input gaps: s_axi4s_tvalid=0 while cke=1 inserts a bubble that propagates to the output as m_axi4s_tvalid=0.
- Simultaneous events: an output beat consumed and an input beat accepted in the same cycle are both handled in that cycle.

## Test plan
- Single beat with scores (class0..9) = 3,9,1,0,127,5,5,2,0,1 and threshold 64 -> after exactly 5 cycles: tclass=4, tcount=127, tdetect=1. The cycle before, tvalid=0.
- Tie beat with all scores = 20 and threshold 20 -> tclass=0, tcount=20, tdetect=1. Scores class3=class7=50 (rest 0) -> tclass=3.
- Below-threshold beat with max at class9 = 30 and threshold 31 -> tclass=9, tcount=30, tdetect=0. Change the threshold to 30 on the next beat (same data) -> that beat gives tdetect=1.
- Back-to-back 640-pixel line, tlast on pixel 639 and tuser on pixel 0, tready always high -> 640 consecutive output beats. tuser is high only on the first, tlast only on the last, and the classes match a software argmax.
- Random tvalid and random tready (50%) over 10,000 beats -> no beat dropped or duplicated, order preserved, and outputs stable during every stall cycle.
- Reset asserted for one cycle with 3 beats in flight -> m_axi4s_tvalid=0 on the next cycle and every output reads 0. The first beat sent after reset emerges after 5 cycles.
